// File: rtl/dice_display_scanner_pkg.sv
// Shared constants for the dice display scanner: 7-segment codes {g,f,e,d,c,b,a}
// and the digit-phase encoding of the scan counter MSB.
package dice_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic PHASE_UNITS = 1'b0;
  localparam logic PHASE_TENS  = 1'b1;

endpackage

// File: rtl/dice_display_scanner_if.sv
// Control/data bundle between the dice counter side and the display scanner.
// The master drives digits and controls; the slave (scanner) drives the pins.
interface dice_display_scanner_if;
  logic       tick;
  logic       load;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       hold;
  logic [2:0] brightness;
  logic       seg_pol;
  logic       com_pol;
  logic [7:0] seg_out;
  logic       com1;
  logic       com10;
  logic       active;

  modport master (
    output tick, load, digit1, digit10, hold, brightness, seg_pol, com_pol,
    input  seg_out, com1, com10, active
  );

  modport slave (
    input  tick, load, digit1, digit10, hold, brightness, seg_pol, com_pol,
    output seg_out, com1, com10, active
  );
endinterface

// File: rtl/dice_display_scanner_decode.sv
// BCD to 7-segment decoder; non-decimal codes show 'E'.
module seg7_bcd_decode
  import dice_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/dice_display_scanner.sv
// Two-digit multiplexed 7-segment scanner with display timeout, leading-zero
// suppression, per-phase dead time, 8-level brightness and selectable polarity.
module dice_display_scanner
  import dice_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W  = 4,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  dice_display_scanner_if.slave bus
);

  localparam logic [SCAN_DIV_W-1:0] DEAD_POS = DEAD_CYCLES[SCAN_DIV_W-1:0];

  logic [3:0]            d1_q, d1_d;
  logic [3:0]            d10_q, d10_d;
  logic [TIMEOUT_W-1:0]  timeout_q, timeout_d;
  logic [SCAN_DIV_W:0]   scan_q, scan_d;
  logic [6:0]            seg_q, seg_d;
  logic                  com1_q, com1_d;
  logic                  com10_q, com10_d;

  logic                  phase;
  logic [SCAN_DIV_W-1:0] pos;
  logic [2:0]            pos_level;
  logic                  lit;
  logic [3:0]            cur_digit;
  logic [6:0]            cur_seg;

  assign phase     = scan_q[SCAN_DIV_W];
  assign pos       = scan_q[SCAN_DIV_W-1:0];
  assign pos_level = pos[SCAN_DIV_W-1 -: 3];
  assign cur_digit = (phase == PHASE_TENS) ? d10_q : d1_q;

  seg7_bcd_decode u_decode (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  // Brightness gates on the top three bits of the in-phase position, so each
  // level adds one eighth of the phase to the on-window.
  always_comb begin
    lit = (timeout_q != '0) && !bus.hold && (pos >= DEAD_POS) &&
          (pos_level <= bus.brightness) && (bus.brightness != 3'd0) &&
          ((phase == PHASE_UNITS) || (d10_q != 4'd0));
  end

  always_comb begin
    d1_d      = d1_q;
    d10_d     = d10_q;
    timeout_d = timeout_q;
    scan_d    = scan_q + 1'b1;
    if (bus.load) begin
      d1_d  = bus.digit1;
      d10_d = bus.digit10;
    end
    if (bus.load || bus.hold) begin
      timeout_d = '1;
    end else if (bus.tick && (timeout_q != '0)) begin
      timeout_d = timeout_q - 1'b1;
    end
    seg_d   = lit ? cur_seg : SEG_BLANK;
    com1_d  = lit && (phase == PHASE_UNITS);
    com10_d = lit && (phase == PHASE_TENS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q      <= '0;
      d10_q     <= '0;
      timeout_q <= '0;
      scan_q    <= '0;
      seg_q     <= '0;
      com1_q    <= 1'b0;
      com10_q   <= 1'b0;
    end else begin
      d1_q      <= d1_d;
      d10_q     <= d10_d;
      timeout_q <= timeout_d;
      scan_q    <= scan_d;
      seg_q     <= seg_d;
      com1_q    <= com1_d;
      com10_q   <= com10_d;
    end
  end

  assign bus.seg_out = bus.seg_pol ? {1'b0, seg_q} : ~{1'b0, seg_q};
  assign bus.com1    = bus.com_pol ? com1_q : ~com1_q;
  assign bus.com10   = bus.com_pol ? com10_q : ~com10_q;
  assign bus.active  = (timeout_q != '0);

endmodule

// File: tb/tb_dice_display_scanner.sv
// Randomized bench for dice_display_scanner against a cycle-level behavioural model.
module tb_dice_display_scanner;

  localparam int W    = 4;
  localparam int DEAD = 2;
  localparam int TW   = 8;
  localparam int SPH  = 1 << W;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dice_display_scanner_if dif ();

  dice_display_scanner #(
    .SCAN_DIV_W  (W),
    .DEAD_CYCLES (DEAD),
    .TIMEOUT_W   (TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16];
  int   m_d1, m_d10, m_to, m_scan;
  logic [6:0] m_seg;
  bit   m_c1, m_c10;
  logic [10:0] exp_vec;

  function automatic logic [10:0] observed();
    return {dif.seg_out, dif.com1, dif.com10, dif.active};
  endfunction

  function automatic logic [10:0] expected();
    logic [7:0] s;
    s = dif.seg_pol ? {1'b0, m_seg} : ~{1'b0, m_seg};
    return {s, dif.com_pol ? m_c1 : !m_c1, dif.com_pol ? m_c10 : !m_c10, m_to != 0};
  endfunction

  // Advance one clock: the model evaluates the display rules from the state and
  // inputs present at the edge, then outputs are sampled 1 time unit after it.
  task automatic step();
    int ph, pos, dg;
    bit lit;
    if (rst) begin
      m_d1 = 0; m_d10 = 0; m_to = 0; m_scan = 0;
      m_seg = 7'h00; m_c1 = 0; m_c10 = 0;
    end else begin
      ph  = m_scan / SPH;
      pos = m_scan % SPH;
      lit = (m_to != 0) && !dif.hold && (pos >= DEAD) &&
            ((pos / (SPH / 8)) <= int'(dif.brightness)) && (dif.brightness != 0) &&
            (ph == 0 || m_d10 != 0);
      dg    = (ph == 1) ? m_d10 : m_d1;
      m_seg = lit ? seg_tab[dg] : 7'h00;
      m_c1  = lit && ph == 0;
      m_c10 = lit && ph == 1;
      if (dif.load) begin
        m_d1  = dif.digit1;
        m_d10 = dif.digit10;
      end
      if (dif.load || dif.hold) m_to = TMAX;
      else if (dif.tick && m_to > 0) m_to = m_to - 1;
      m_scan = (m_scan + 1) % (2 * SPH);
    end
    @(posedge clk);
    #1;
    exp_vec = expected();
  endtask

  task automatic do_load(input int d10, input int d1);
    dif.digit10 = 4'(d10);
    dif.digit1  = 4'(d1);
    dif.load    = 1'b1;
    step();
    dif.load    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.seg_pol = 1'b1;
    dif.com_pol = 1'b0;
    step();
    step();
    n_vec++;
    if (observed() !== 11'({8'h00, 1'b1, 1'b1, 1'b0})) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", observed(), 11'({8'h00, 1'b1, 1'b1, 1'b0}));
    end
    dif.seg_pol = 1'b0;
    #1;
    n_vec++;
    if (dif.seg_out !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_seg_inv: got %h want ff", dif.seg_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_digits();
    int hits_u, hits_t;
    hits_u = 0; hits_t = 0;
    dif.seg_pol = 1'b1; dif.com_pol = 1'b1; dif.brightness = 3'd7;
    do_load(1, 2);
    for (int i = 0; i < 4 * SPH; i++) begin
      step();
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL digits_12 cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
      if (dif.com1 && dif.seg_out == 8'h5B) hits_u++;
      if (dif.com10 && dif.seg_out == 8'h06) hits_t++;
      if (dif.com1 && dif.com10) begin
        n_err++;
        $display("FAIL both_commons cyc %0d: got 1 want 0", i);
      end
    end
    n_vec++;
    if (hits_u != 2 * (SPH - DEAD) || hits_t != 2 * (SPH - DEAD)) begin
      n_err++;
      $display("FAIL digits_lit_count: got %0d/%0d want %0d", hits_u, hits_t, 2 * (SPH - DEAD));
    end
  endtask

  task automatic test_leading_zero();
    int c10, c7;
    c10 = 0; c7 = 0;
    do_load(0, 7);
    for (int i = 0; i < 4 * SPH; i++) begin
      step();
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL lead_zero cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
      if (dif.com10) c10++;
      if (dif.com1 && dif.seg_out == 8'h07) c7++;
    end
    n_vec++;
    if (c10 != 0 || c7 != 2 * (SPH - DEAD)) begin
      n_err++;
      $display("FAIL lead_zero_counts: got com10=%0d u7=%0d want 0 %0d", c10, c7, 2 * (SPH - DEAD));
    end
  endtask

  task automatic test_brightness();
    int on_cnt, b;
    do_load(4, 5);
    for (int k = 0; k < 6; k++) begin
      b = (k == 0) ? 3 : (k == 1) ? 0 : int'($urandom_range(0, 7));
      dif.brightness = 3'(b);
      step();
      on_cnt = 0;
      for (int i = 0; i < 2 * SPH; i++) begin
        step();
        n_vec++;
        if (observed() !== exp_vec) begin
          n_err++;
          $display("FAIL bright_%0d cyc %0d: got %h want %h", b, i, observed(), exp_vec);
        end
        if (dif.com1 || dif.com10) on_cnt++;
      end
      n_vec++;
      if (b == 3 && on_cnt != 12) begin
        n_err++;
        $display("FAIL bright3_window: got %0d want 12", on_cnt);
      end else if (b == 0 && on_cnt != 0) begin
        n_err++;
        $display("FAIL bright0_dark: got %0d want 0", on_cnt);
      end
    end
    dif.brightness = 3'd7;
  endtask

  task automatic test_timeout();
    dif.tick = 1'b1;
    do_load(3, 6);
    dif.tick = 1'b0;
    n_vec++;
    if (dut.timeout_q !== 8'hFF) begin
      n_err++;
      $display("FAIL load_vs_tick: got %h want ff", dut.timeout_q);
    end
    for (int t = 1; t <= TMAX; t++) begin
      dif.tick = 1'b1;
      step();
      dif.tick = 1'b0;
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL timeout tick %0d: got %h want %h", t, observed(), exp_vec);
      end
      if (t == TMAX - 1 || t == TMAX) begin
        n_vec++;
        if (dif.active !== (t == TMAX - 1)) begin
          n_err++;
          $display("FAIL active_at_tick_%0d: got %b want %b", t, dif.active, t == TMAX - 1);
        end
      end
      step();
    end
    dif.tick = 1'b1;
    step();
    dif.tick = 1'b0;
    step();
    n_vec++;
    if (observed() !== 11'({8'h00, 1'b0, 1'b0, 1'b0}) || m_to != 0) begin
      n_err++;
      $display("FAIL timeout_blank: got %h want 000", observed());
    end
  endtask

  task automatic test_hold();
    do_load(2, 3);
    dif.hold = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_vec++;
      if (observed() !== exp_vec || (i > 0 && observed() !== 11'({8'h00, 1'b0, 1'b0, 1'b1}))) begin
        n_err++;
        $display("FAIL hold cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
    end
    n_vec++;
    if (dut.timeout_q !== 8'hFF) begin
      n_err++;
      $display("FAIL hold_timeout: got %h want ff", dut.timeout_q);
    end
    dif.hold = 1'b0;
    for (int i = 0; i < 2 * SPH; i++) begin
      step();
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL hold_release cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
    end
  endtask

  task automatic test_error_code();
    int e_cnt;
    e_cnt = 0;
    do_load(0, 12);
    for (int i = 0; i < 2 * SPH; i++) begin
      step();
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL err_code cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
      if (dif.com1 && dif.seg_out == 8'h79) e_cnt++;
    end
    n_vec++;
    if (e_cnt != SPH - DEAD) begin
      n_err++;
      $display("FAIL err_code_count: got %0d want %0d", e_cnt, SPH - DEAD);
    end
  endtask

  task automatic test_reset_midphase();
    do_load(8, 8);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (observed() !== exp_vec || observed() !== 11'({8'h00, 1'b0, 1'b0, 1'b0})) begin
      n_err++;
      $display("FAIL reset_midphase: got %h want 000", observed());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      dif.load       = ($urandom_range(0, 29) == 0);
      dif.tick       = ($urandom_range(0, 1) == 0);
      dif.hold       = ($urandom_range(0, 39) == 0) ? !dif.hold : dif.hold;
      dif.digit1     = 4'($urandom);
      dif.digit10    = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      if ($urandom_range(0, 49) == 0) dif.brightness = 3'($urandom);
      if ($urandom_range(0, 99) == 0) dif.seg_pol = !dif.seg_pol;
      if ($urandom_range(0, 99) == 0) dif.com_pol = !dif.com_pol;
      step();
      n_vec++;
      if (observed() !== exp_vec) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h want %h", i, observed(), exp_vec);
      end
    end
    rst = 1'b0; dif.load = 1'b0; dif.tick = 1'b0; dif.hold = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    rst = 1'b1;
    dif.tick = 1'b0; dif.load = 1'b0; dif.hold = 1'b0;
    dif.digit1 = 4'd0; dif.digit10 = 4'd0; dif.brightness = 3'd7;
    dif.seg_pol = 1'b1; dif.com_pol = 1'b0;
    test_reset();
    test_digits();
    test_leading_zero();
    test_brightness();
    test_timeout();
    test_hold();
    test_error_code();
    test_reset_midphase();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dice_display_scanner.md
Name: dice_display_scanner

Overview:
- Downstream consumer of the dice digit counter. Drives a two-digit multiplexed 7-segment display from BCD digit1/digit10.
- Latches digits on a load pulse and blanks while buttons are held.
- Adds a display-on timeout, leading-zero suppression, dead-time between digit phases against ghosting, and 8-level brightness gating.
- Output polarity is runtime-selectable per pin group, covering common-anode and common-cathode displays.

Parameters:
- SCAN_DIV_W, 4: width of the in-phase position counter; each digit phase lasts 2^SCAN_DIV_W cycles; must be >= 3.
- DEAD_CYCLES, 2: blank cycles at the start of each phase; must be < 2^SCAN_DIV_W.
- TIMEOUT_W, 8: width of the display-on timeout counter, measured in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle timebase pulse, nominally 32 Hz.
- load  in  1  one-cycle pulse; capture digit1/digit10 and restart the timeout.
- digit1  in  4  units digit, BCD.
- digit10  in  4  tens digit, BCD.
- hold  in  1  a button is held; forces the display blank and keeps the timeout full.
- brightness  in  3  0 = dark, 7 = maximum on-time.
- seg_pol  in  1  1 = segments active-high.
- com_pol  in  1  1 = common drives active-high.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}; dp is always inactive.
- com1  out  1  units-digit common drive.
- com10  out  1  tens-digit common drive.
- active  out  1  timeout counter is non-zero.

Behaviour:
- Reset:
  - d1_q = 0, d10_q = 0, timeout = 0, scan counter = 0.
  - Internal active-high seg/com registers = 0, so outputs sit at inactive levels: seg_out = seg_pol ? 8'h00 : 8'hFF; com* = ~com_pol.
  - active = 0.
- Digit latch: on load, d1_q/d10_q capture the inputs; they are visible to decode from the next cycle.
- Timeout counter (priority order):
  - rst → 0.
  - load or hold → all-ones (2^TIMEOUT_W - 1).
  - tick with counter != 0 → decrement.
  - tick at 0 → stays 0; no wrap.
  - active = (timeout != 0), driven combinationally from the register.
- Scan counter:
  - Free-running, SCAN_DIV_W+1 bits, wraps naturally.
  - MSB is phase: 0 = units, 1 = tens. Low bits are pos.
  - Unaffected by load, hold or tick.
- Lit condition: lit = active & ~hold & (pos >= DEAD_CYCLES) & ((pos >> (SCAN_DIV_W-3)) <= brightness) & (brightness != 0).
- Phase 1 additionally requires d10_q != 0 (leading-zero suppression).
- Decode: 0..9 → 3F,06,5B,4F,66,6D,7D,07,7F,6F. Codes 10..15 → 79 ('E').
- Registered stage, one cycle of latency:
  - seg_r = lit ? decode(phase ? d10_q : d1_q) : 0.
  - com1_r = lit & ~phase; com10_r = lit & phase.
  - Both commons are never active in the same cycle.
- Polarity is applied combinationally after the registers: seg_out = seg_pol ? seg_r : ~seg_r; com* = com_pol ? com*_r : ~com*_r.
- Simultaneous load and tick: load wins; the counter goes to all-ones.
- hold rising mid-phase: outputs blank starting one cycle later. hold release: display resumes at the current scan position with a full timeout.
- rst asserted mid-phase: all state clears the same edge; outputs go inactive in the following cycle.

Decomposition:
- Package dice_disp_pkg holds:
  - the segment code constants SEG_0..SEG_9 and SEG_E;
  - the SEG_BLANK constant;
  - localparam PHASE_UNITS / PHASE_TENS.
- One sub-module, seg7_bcd_decode: purely combinational, 4-bit in, 7-bit out, uses the package constants.

Test Plan:
- Reset with seg_pol=1, com_pol=0 → seg_out=00, com1=com10=1, active=0. Then seg_pol=0 → seg_out=FF.
- load digit10=1, digit1=2, brightness=7, pols=1 → phase 0 pos 2..15: seg_out=5B, com1=1. Phase 1: seg_out=06, com10=1. pos 0..1 of each phase blank, both commons 0, with 1-cycle latency.
- load digit10=0, digit1=7 → com10 never asserts. Units phase shows 07.
- brightness=3, SCAN_DIV_W=4 → lit only at pos 2..7 of each phase (6 cycles per phase); brightness=0 → never lit.
- load, then 255 ticks, no buttons → active=1 through tick 254 and drops after tick 255; outputs blank. Load coincident with a tick → counter=FF.
- hold=1 for 100 cycles after load → all outputs inactive, timeout stays FF. After release, digits resume. digit1=12 latched → seg_out=79.
